// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary conversion path.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int NDIG       = 3;
  localparam int BW         = 10;
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_VAL    = 3;
  localparam int DIGIT_MAX  = 9;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: a field of 8 or more
// after the right shift had a borrowed 10 worth of weight, so subtract 3.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  import bcd_pkg::*;

  always_comb begin
    dout = din;
    if (din >= 4'(ADJ_THRESH)) dout = din - 4'(ADJ_VAL);
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential three-digit BCD to binary converter (reverse double-dabble) with
// start/busy/done handshake and non-decimal digit rejection.
module bcd_to_bin #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    bcd2,
  input  logic [3:0]    bcd1,
  input  logic [3:0]    bcd0,
  output logic [BW-1:0] bin,
  output logic          busy,
  output logic          done,
  output logic          err
);
  import bcd_pkg::*;

  localparam int DW = 4 * NDIG;
  localparam int WW = DW + BW;
  localparam int CW = $clog2(BW + 1);

  state_t        state, state_nxt;
  logic [WW-1:0] work, shifted, work_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] digits_in;
  logic          digit_bad, accept, reject, last;

  assign digits_in = {bcd2, bcd1, bcd0};

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (digits_in[4*i +: 4] > 4'(DIGIT_MAX)) digit_bad = 1'b1;
  end

  // Shift and per-digit correction form a single register update.
  assign shifted = work >> 1;
  assign work_nxt[BW-1:0] = shifted[BW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shifted[BW+4*g +: 4]),
      .dout (work_nxt[BW+4*g +: 4])
    );
  end

  assign accept = (state == IDLE) && start && !digit_bad;
  assign reject = (state == IDLE) && start && digit_bad;
  assign last   = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
      bin  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= reject | last;
      if (accept) begin
        work <= {digits_in, {BW{1'b0}}};
        cnt  <= CW'(BW);
        err  <= 1'b0;
      end else if (state == SHIFT) begin
        work <= work_nxt;
        cnt  <= cnt - CW'(1);
        if (last) bin <= work_nxt[BW-1:0];
      end
      if (reject) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expectations queued at start, checked at done.
module tb_bcd_to_bin;

  localparam int BW_T = 10;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [3:0]      bcd2, bcd1, bcd0;
  logic [BW_T-1:0] bin;
  logic            busy, done, err;

  bcd_to_bin dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW_T-1:0] bin;
    logic            err;
  } exp_t;

  exp_t            sb[$];
  logic [BW_T-1:0] last_bin;
  int              n_run, n_fail;

  // Drive a one-cycle start and queue the expected outcome.
  task automatic drive_start(input int d2, input int d1, input int d0);
    exp_t e;
    bcd2  = 4'(d2);
    bcd1  = 4'(d1);
    bcd0  = 4'(d0);
    start = 1'b1;
    if (d2 <= 9 && d1 <= 9 && d0 <= 9) begin
      e.bin    = BW_T'(d2 * 100 + d1 * 10 + d0);
      e.err    = 1'b0;
      last_bin = e.bin;
    end else begin
      e.bin = last_bin;
      e.err = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat counts edges after the accepting edge until done is seen.
  task automatic wait_done(output bit seen, output int lat, output int nbusy);
    seen  = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!seen && lat <= 40) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (bin  !== '0)   begin n_fail++; $display("FAIL reset_bin: got %0h want 0", bin); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_run++; if (err  !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    rst = 1'b0;
    last_bin = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_valid;
    int   tab [3][3] = '{'{2, 5, 5}, '{9, 9, 9}, '{0, 0, 0}};
    bit   seen;
    int   lat, nb;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_start(tab[i][0], tab[i][1], tab[i][2]);
      wait_done(seen, lat, nb);
      e = sb.pop_front();
      n_run++; if (!seen || lat != BW_T) begin n_fail++; $display("FAIL valid_latency[%0d]: got %0d (seen %0b) want %0d", i, lat, seen, BW_T); end
      n_run++; if (nb != BW_T)           begin n_fail++; $display("FAIL valid_busy_cycles[%0d]: got %0d want %0d", i, nb, BW_T); end
      n_run++; if (bin !== e.bin)        begin n_fail++; $display("FAIL valid_bin[%0d]: got %0h want %0h", i, bin, e.bin); end
      n_run++; if (err !== e.err)        begin n_fail++; $display("FAIL valid_err[%0d]: got %0b want %0b", i, err, e.err); end
      n_run++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL valid_busy_at_done[%0d]: got %0b want 0", i, busy); end
      @(posedge clk); #1;
      n_run++; if (done !== 1'b0)        begin n_fail++; $display("FAIL valid_done_width[%0d]: got %0b want 0", i, done); end
    end
  endtask

  task automatic test_error;
    bit   seen;
    int   lat, nb;
    exp_t e;
    drive_start(1, 2, 3);
    wait_done(seen, lat, nb);
    e = sb.pop_front();
    n_run++; if (!seen || bin !== e.bin) begin n_fail++; $display("FAIL err_pre_bin: got %0h want %0h", bin, e.bin); end
    @(posedge clk); #1;
    drive_start(1, 10, 0);
    wait_done(seen, lat, nb);
    e = sb.pop_front();
    n_run++; if (!seen || lat != 0) begin n_fail++; $display("FAIL err_latency: got %0d (seen %0b) want 0", lat, seen); end
    n_run++; if (err !== e.err)     begin n_fail++; $display("FAIL err_flag: got %0b want %0b", err, e.err); end
    n_run++; if (bin !== e.bin)     begin n_fail++; $display("FAIL err_bin_held: got %0h want %0h", bin, e.bin); end
    n_run++; if (nb != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_busy: got %0b/%0d want 0", busy, nb); end
    @(posedge clk); #1;
    n_run++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_after: got done %0b busy %0b want 0 0", done, busy); end
    n_run++; if (err !== 1'b1)      begin n_fail++; $display("FAIL err_hold: got %0b want 1", err); end
  endtask

  task automatic test_ignore_start;
    exp_t            e;
    int              ndone, lat_obs;
    logic [BW_T-1:0] cap;
    drive_start(4, 5, 6);
    e = sb.pop_front();
    ndone = 0; lat_obs = -1; cap = '0;
    for (int c = 1; c <= 24; c++) begin
      if (c <= 6) begin
        start = c[0];
        bcd2  = 4'($urandom_range(0, 15));
        bcd1  = 4'($urandom_range(0, 15));
        bcd0  = 4'($urandom_range(0, 15));
      end else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; cap = bin; lat_obs = c; end
    end
    n_run++; if (ndone != 1)     begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    n_run++; if (lat_obs != BW_T) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat_obs, BW_T); end
    n_run++; if (cap !== e.bin)  begin n_fail++; $display("FAIL ignore_bin: got %0h want %0h", cap, e.bin); end
    n_run++; if (err !== e.err)  begin n_fail++; $display("FAIL ignore_err: got %0b want %0b", err, e.err); end
  endtask

  task automatic test_reset_mid;
    bit   seen;
    int   lat, nb, ndone;
    exp_t e;
    drive_start(7, 8, 9);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++; if (bin  !== '0)   begin n_fail++; $display("FAIL rstmid_bin: got %0h want 0", bin); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %0b want 0", done); end
    n_run++; if (err  !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %0b want 0", err); end
    rst = 1'b0;
    sb.delete();
    last_bin = '0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_run++; if (ndone != 0) begin n_fail++; $display("FAIL rstmid_abandon: got %0d active cycles want 0", ndone); end
    drive_start(0, 4, 2);
    wait_done(seen, lat, nb);
    e = sb.pop_front();
    n_run++; if (!seen || bin !== e.bin) begin n_fail++; $display("FAIL rstmid_fresh: got %0h want %0h", bin, e.bin); end
  endtask

  task automatic test_back_to_back;
    bit   seen;
    int   lat, nb;
    exp_t e;
    drive_start(0, 0, 0);
    for (int v = 0; v < 512; v++) begin
      wait_done(seen, lat, nb);
      e = sb.pop_front();
      n_run++; if (!seen || bin !== e.bin || err !== e.err) begin
        n_fail++; $display("FAIL roundtrip[%0d]: got %0h err %0b want %0h err %0b", v, bin, err, e.bin, e.err);
      end
      if (v < 511) begin
        drive_start((v + 1) / 100, ((v + 1) / 10) % 10, (v + 1) % 10);
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: got busy %0b want 1", v + 1, busy); end
      end
    end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    test_reset;
    test_valid;
    test_error;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter for three decimal digits (0–999), using reverse double-dabble: shift right, then adjust each digit. It is the inverse of the combinational binary-to-BCD converter that feeds the 7-segment display path. It turns digit-entry values, such as digits set on switches or stepped with buttons, into a binary operand for the 8-bit adder/subtractor. It uses a start/busy/done handshake and reports non-decimal digits instead of converting them.

## Interface
- `NDIG`, 3, number of BCD digits accepted.
- `BW`, 10, binary result width. Must satisfy 2^BW > 10^NDIG − 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bcd2`  in  4  hundreds digit.
- `bcd1`  in  4  tens digit.
- `bcd0`  in  4  units digit.
- `bin`  out  BW  last converted value; registered.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when a request completes (valid or error).
- `err`  out  1  last accepted request had a digit > 9; registered.

## Operation
- Reset values: state IDLE; `bin` = 0, `busy` = 0, `done` = 0, `err` = 0; shift register and counter cleared.
- States: IDLE, SHIFT.
- **IDLE, `start` = 1, all digits ≤ 9:**
  - Latch {bcd2, bcd1, bcd0} into the upper 4·NDIG bits of a (4·NDIG + BW)-bit work register; lower BW bits = 0.
  - Counter = BW; clear `err`; go to SHIFT.
- **IDLE, `start` = 1, any digit ≥ 10:**
  - Stay in IDLE; `err` = 1; `done` pulses next cycle.
  - `bin` is unchanged; no shifting occurs.
- **SHIFT, each cycle:**
  - Shift the work register right by 1 (MSB ← 0).
  - For each 4-bit digit field of the shifted value: if field ≥ 8, field −= 3.
  - Both steps are one combined register update.
  - Decrement the counter. When it reaches 0, load `bin` from the lower BW bits, pulse `done`, and return to IDLE.
- `start` while in SHIFT is ignored; it is not queued.
- Digit inputs are sampled only on the accepting edge; later changes do not affect an ongoing conversion.
- `bin` holds the last valid result until the next successful completion.
- `err` holds until the next accepted `start`.
- Reset during SHIFT abandons the conversion; all outputs return to their reset values on that edge.

## Timing
- `start` accepted at edge k → `busy` = 1 from after edge k through the cycle before edge k+BW.
- Valid request: after edge k+BW, `done` = 1 for exactly one cycle, `bin` is valid, `busy` = 0. Latency is BW cycles (10 by default).
- Invalid request: after edge k, `done` = 1 and `err` = 1 for one cycle; `busy` never rises. Latency is 1 cycle.
- FSM is back in IDLE during the `done` cycle, so `start` asserted in that cycle is accepted (back-to-back throughput is one conversion per BW+1 cycles).
- `rst` has priority over `start` on the same edge.

## Structure
- Shared package `bcd_pkg`: state enum {IDLE, SHIFT}; constants NDIG = 3, BW = 10, ADJ_THRESH = 8, ADJ_VAL = 3, DIGIT_MAX = 9.
- Sub-module `bcd_digit_adj`: combinational 4-bit "if ≥ 8 subtract 3", instantiated NDIG times via generate.
- The top level holds the FSM, counter (width ⌈log2(BW+1)⌉), work register, and output registers.

## Test plan
- Digits 2,5,5, start pulse → `busy` for 10 cycles, then `done` pulse with `bin` = 0x0FF, `err` = 0.
- Digits 9,9,9 → `bin` = 0x3E7. Digits 0,0,0 → `bin` = 0x000. Both have latency 10 cycles.
- Valid conversion (1,2,3 → 0x07B), then digits 1,10,0 → `done` and `err` = 1 one cycle after start; `bin` stays 0x07B; `busy` stays 0.
- Start 4,5,6, then toggle `start` and change digits mid-conversion → `bin` = 0x1C8 after 10 cycles; exactly one `done` pulse.
- Assert `rst` at cycle 5 of a conversion → next cycle all outputs 0, state IDLE; no `done`. A fresh start of 0,4,2 yields 0x02A.
- Round trip: sweep 0–511 through the binary-to-BCD converter into this block → `bin` equals the original value every time; `start` is reissued on the `done` cycle to check back-to-back acceptance.
